// File: rtl/mul_accumulator_pkg.sv
// Shared types and defaults for the multiplier accumulator.
// Imported by the accumulator top and its output FIFO.
package mul_pkg;

    localparam int N_DEF           = 16;
    localparam int M_DEF           = 16;
    localparam int ACC_W_DEF       = 40;
    localparam int MUL_LATENCY_DEF = 4;

    typedef enum logic {
        IDLE,
        ACCUM
    } acc_state_e;

    typedef struct packed {
        logic                 ovf;
        logic [ACC_W_DEF-1:0] sum;
    } acc_entry_t;

endpackage

// File: rtl/mul_accumulator_if.sv
// Result handshake between the accumulator and its consumer.
// Master presents results, slave accepts them with out_ready.
interface mul_accumulator_if #(
    parameter int ACC_W = mul_pkg::ACC_W_DEF
);
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output out_valid,
        output out_data,
        output out_ovf,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_ovf,
        output out_ready
    );
endinterface

// File: rtl/mul_accumulator_fifo.sv
// Two-entry valid/ready result buffer with a full flag.
// Push while full is only taken when the head pops that cycle.
module acc_out_fifo
    import mul_pkg::*;
#(
    parameter type entry_t = acc_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   ready,
    output logic   valid,
    output entry_t head,
    output logic   full
);

    entry_t     mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       pop;
    logic       wr_en;

    assign valid = (count != 2'd0);
    assign full  = (count == 2'd2);
    assign head  = mem[rd_ptr];
    assign pop   = valid & ready;
    assign wr_en = push & (~full | pop);

    // Storage, pointers and occupancy; full-with-pop reuses the freed slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_accumulator.sv
// Aligns operand tags with the multiplier pipeline and sums
// products into saturating group results behind a 2-entry buffer.
module mul_accumulator
    import mul_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int M           = M_DEF,
    parameter int ACC_W       = ACC_W_DEF,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   op_valid,
    input  logic                   op_last,
    input  logic [N+M-1:0]         product,
    mul_accumulator_if.master      out,
    output logic                   err_overrun
);

    typedef struct packed {
        logic             ovf;
        logic [ACC_W-1:0] sum;
    } entry_t;

    logic [MUL_LATENCY-1:0] v_sr;
    logic [MUL_LATENCY-1:0] l_sr;
    logic                   d_valid;
    logic                   d_last;

    acc_state_e       state_q;
    acc_state_e       state_d;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;

    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] base_acc;
    logic             base_ovf;
    logic [ACC_W:0]   sum_w;
    logic             sat;
    logic [ACC_W-1:0] acc_new;

    logic   push;
    entry_t push_data;
    logic   fifo_valid;
    logic   fifo_full;
    entry_t head;
    logic   drop;

    assign d_valid = v_sr[MUL_LATENCY-1];
    assign d_last  = l_sr[MUL_LATENCY-1];

    // Tag delay line matching the multiplier depth.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v_sr <= '0;
            l_sr <= '0;
        end else begin
            v_sr <= {v_sr[MUL_LATENCY-2:0], op_valid};
            l_sr <= {l_sr[MUL_LATENCY-2:0], op_valid & op_last};
        end
    end

    assign ext      = ACC_W'(product);
    assign base_acc = (state_q == ACCUM) ? acc_q : '0;
    assign base_ovf = (state_q == ACCUM) & ovf_q;
    assign sum_w    = {1'b0, base_acc} + {1'b0, ext};
    assign sat      = base_ovf | sum_w[ACC_W];
    assign acc_new  = sat ? '1 : sum_w[ACC_W-1:0];

    // Next group state and result push on each aligned product.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_valid) begin
                    state_d = d_last ? IDLE : ACCUM;
                    push    = d_last;
                end
            end
            ACCUM: begin
                if (d_valid) begin
                    state_d = d_last ? IDLE : ACCUM;
                    push    = d_last;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Group state and running sum.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (d_valid) begin
                acc_q <= acc_new;
                ovf_q <= sat;
            end
        end
    end

    assign push_data = '{ovf: sat, sum: acc_new};

    acc_out_fifo #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .ready     (out.out_ready),
        .valid     (fifo_valid),
        .head      (head),
        .full      (fifo_full)
    );

    assign out.out_valid = fifo_valid;
    assign out.out_data  = head.sum;
    assign out.out_ovf   = head.ovf;

    assign drop = push & fifo_full & ~(fifo_valid & out.out_ready);

    // Sticky flag for a result lost to a full buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_overrun <= 1'b0;
        end else if (drop) begin
            err_overrun <= 1'b1;
        end
    end

endmodule

// File: doc/mul_accumulator.md
# mul_accumulator

Downstream consumer of the `PIPELINED_MUL` stage: it aligns an operand-side valid/last tag with the multiplier's fixed pipeline latency. It then accumulates successive products into dot-product results and hands each finished result out through a 2-entry valid/ready buffer. The multiplier cannot stall, so overflow of the output buffer is detected and flagged rather than back-pressured.

## Interface
- `N`, 16, multiplicand width
- `M`, 16, multiplier width
- `ACC_W`, 40, accumulator width; must be ≥ N+M
- `MUL_LATENCY`, 4, cycles from operands applied to `Product` valid; set equal to the `PIPELINED_MUL` instance depth

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-low reset
- `op_valid`  in  1  operands are presented to the multiplier this cycle
- `op_last`  in  1  marks the final pair of a group; ignored unless `op_valid`
- `product`  in  N+M  `Product` output of the multiplier, unsigned
- `out_valid`  out  1  result available at buffer head
- `out_ready`  in  1  consumer accepts head this cycle
- `out_data`  out  ACC_W  accumulated group sum
- `out_ovf`  out  1  the head result saturated
- `err_overrun`  out  1  sticky: a finished result was dropped because the buffer was full

## Operation
- Tag delay line: a shift register of {valid, last}, `MUL_LATENCY` deep. Its tap `d_valid`/`d_last` is aligned with `product`.
- Accumulator FSM, 2 states:
  - IDLE (no group open): on `d_valid & !d_last`, load `product` and go to ACCUM. On `d_valid & d_last`, push `product` as a single-element result and stay in IDLE.
  - ACCUM: on `d_valid`, add `product`. On `d_valid & d_last`, push the sum and go to IDLE. Cycles without `d_valid` hold state.
- Arithmetic: `product` is zero-extended to ACC_W and added unsigned. A carry out of ACC_W saturates the accumulator to all-ones and sets the group's ovf bit. Once saturated, the value stays saturated until the group ends. The ovf bit clears when a new group starts.
- Output buffer: 2 entries of {ovf, sum}, FIFO order. The head drives `out_data`/`out_ovf`.
  - Pop on `out_valid & out_ready`.
  - A simultaneous push and pop is always legal, including when the buffer is full.
  - A push with 2 entries held and no pop drops the new result and sets `err_overrun`.
- `out_data`/`out_ovf` hold stable while `out_valid & !out_ready`.
- Reset (`rst`=0 at an edge) has the following effects:
  - Tag line cleared, so in-flight operands are discarded.
  - FSM returns to IDLE and any partial sum is discarded.
  - Buffer emptied.
  - All outputs go to 0: `out_valid`, `out_data`, `out_ovf`, `err_overrun`.

## Timing
- Operands at cycle t with `op_valid` → `product` consumed at cycle t+MUL_LATENCY.
- Accumulator and buffer update at the end of cycle t+MUL_LATENCY. `out_valid` is high from t+MUL_LATENCY+1.
- Result latency: MUL_LATENCY+1 cycles after the `op_last` pair is applied.
- Throughput: one operand pair per cycle; back-to-back groups need no gap cycle.
- `err_overrun` asserts the cycle after the dropped push and holds until reset.
- First usable input: the cycle after `rst` is sampled high.

## Structure
- Shared package `mul_pkg`:
  - default N, M, ACC_W, MUL_LATENCY
  - FSM state typedef (IDLE, ACCUM)
  - buffer-entry struct {ovf, sum}
- Sub-module `acc_out_fifo`: 2-entry valid/ready FIFO with a `full` output. It is instantiated once.
- Tag delay line, FSM and saturating adder live in the top level.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `op_valid`=1 → `out_valid`=0, `out_data`=0, `err_overrun`=0. No output appears for the operands applied during reset.
- Group of 3: (3,4), (5,6), (7,8), `op_last` on the third, `out_ready`=1 → `out_valid` is high for exactly one cycle, MUL_LATENCY+1 after the third pair, with `out_data`=98 and `out_ovf`=0.
- Single-element group: (65535,65535) with `op_last` → `out_data`=4294836225, `out_ovf`=0.
- Saturation (ACC_W=34 build): five (65535,65535) pairs, last flagged, → `out_data`=17179869183 and `out_ovf`=1. A following group (2,3) → 6 with `out_ovf`=0.
- Back-pressure: `out_ready`=0, three single-element groups (1,1), (2,2), (3,3) back-to-back → the buffer holds 1 and 4, 9 is dropped, and `err_overrun`=1. Raising `out_ready` pops 1 then 4, then `out_valid`=0.
- Reset mid-group: apply (9,9), (9,9) without last, pulse `rst`=0 for one cycle, then apply (2,2) with `op_last` → the single output is `out_data`=4.
